// File: rtl/enc_bundler.sv
// Bundles NUM_HV bound hypervectors per sample into one thresholded hypervector
// using a per-bit population counter.
module enc_bundler #(
    parameter int unsigned HV_DIM    = 1024,
    parameter int unsigned NUM_HV    = 80,
    parameter int unsigned CNT_W     = $clog2(NUM_HV + 1),
    parameter int unsigned THRESHOLD = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_bundling,
    input  logic              bound_valid,
    input  logic [HV_DIM-1:0] bound_hv,
    output logic              busy,
    output logic [CNT_W-1:0]  hv_count,
    output logic [HV_DIM-1:0] bundled_hv,
    output logic              bundle_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        THRESH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_HV - 1);
    localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESHOLD);

    state_t           state;
    logic [CNT_W-1:0] cnt [HV_DIM];

    // Sample FSM with per-bit counters; busy tracks state != IDLE as a register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            hv_count     <= '0;
            bundled_hv   <= '0;
            bundle_valid <= 1'b0;
            for (int b = 0; b < int'(HV_DIM); b++) begin
                cnt[b] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    bundle_valid <= 1'b0;
                    if (start_bundling) begin
                        for (int b = 0; b < int'(HV_DIM); b++) begin
                            cnt[b] <= '0;
                        end
                        hv_count <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bound_valid) begin
                        // Saturation is only a guard; CNT_W already covers NUM_HV.
                        for (int b = 0; b < int'(HV_DIM); b++) begin
                            if (bound_hv[b] && (cnt[b] != CNT_MAX)) begin
                                cnt[b] <= cnt[b] + 1'b1;
                            end
                        end
                        hv_count <= hv_count + 1'b1;
                        if (hv_count == LAST_IDX) begin
                            state <= THRESH;
                        end
                    end
                end
                THRESH: begin
                    for (int b = 0; b < int'(HV_DIM); b++) begin
                        bundled_hv[b] <= (cnt[b] >= THR);
                    end
                    bundle_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    bundle_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    bundle_valid <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_bundler.sv
// Directed bench for enc_bundler: table of sample patterns plus gapped,
// reset-mid-sample and back-to-back sequences. A second instance uses THRESHOLD=80.
module tb_enc_bundler;

    localparam int unsigned HV_DIM = 1024;
    localparam int unsigned NUM_HV = 80;
    localparam int unsigned CNT_W  = 7;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start_bundling = 1'b0;
    logic              bound_valid = 1'b0;
    logic [HV_DIM-1:0] bound_hv = '0;

    logic              busy, bundle_valid;
    logic [CNT_W-1:0]  hv_count;
    logic [HV_DIM-1:0] bundled_hv;

    logic              busy_t80, bundle_valid_t80;
    logic [CNT_W-1:0]  hv_count_t80;
    logic [HV_DIM-1:0] bundled_hv_t80;

    enc_bundler #(.HV_DIM(HV_DIM), .NUM_HV(NUM_HV), .THRESHOLD(2)) dut (
        .clk(clk), .nrst(nrst), .start_bundling(start_bundling),
        .bound_valid(bound_valid), .bound_hv(bound_hv), .busy(busy),
        .hv_count(hv_count), .bundled_hv(bundled_hv), .bundle_valid(bundle_valid)
    );

    enc_bundler #(.HV_DIM(HV_DIM), .NUM_HV(NUM_HV), .THRESHOLD(80)) dut_t80 (
        .clk(clk), .nrst(nrst), .start_bundling(start_bundling),
        .bound_valid(bound_valid), .bound_hv(bound_hv), .busy(busy_t80),
        .hv_count(hv_count_t80), .bundled_hv(bundled_hv_t80),
        .bundle_valid(bundle_valid_t80)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bundle_valid) begin
            pulse_cnt  <= pulse_cnt + 1;
            last_pulse <= cyc;
        end
    end

    // Sample pattern: base bits in every HV, bit ba in the first na, bit bb in the first nb.
    typedef struct {
        logic [HV_DIM-1:0] base;
        int                ba;
        int                na;
        int                bb;
        int                nb;
        logic [HV_DIM-1:0] exp2;
        logic [HV_DIM-1:0] exp80;
    } vec_t;

    localparam int NVEC = 5;
    localparam int V_ONES = 0, V_EDGE = 1, V_PARAM = 2, V_ZERO = 3;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_hv(input string nm, input logic [HV_DIM-1:0] act,
                          input logic [HV_DIM-1:0] exp);
        logic [HV_DIM-1:0] diff;
        diff = act ^ exp;
        n_chk++;
        if (diff !== '0) begin
            n_err++;
            $display("FAIL %s: %0d bits differ, got ones=%0d low=%h expected ones=%0d low=%h (t=%0t)",
                     nm, $countones(diff), $countones(act), act[63:0],
                     $countones(exp), exp[63:0], $time);
        end
    endtask

    function automatic logic [HV_DIM-1:0] pattern(input int v, input int i);
        logic [HV_DIM-1:0] hv;
        hv = vecs[v].base;
        if (i < vecs[v].na) hv[vecs[v].ba] = 1'b1;
        if (i < vecs[v].nb) hv[vecs[v].bb] = 1'b1;
        return hv;
    endfunction

    // Runs one full sample of vector v; called just after a negedge with the DUT in IDLE.
    task automatic run_sample(input int v, input bit gapped);
        int g;
        logic [CNT_W-1:0] prev;
        if (gapped) begin
            prev = hv_count;
            bound_valid = 1'b1;
            bound_hv    = '1;
            repeat (3) @(negedge clk);
            chk("idle_valid_hv_count", 32'(hv_count), 32'(prev));
            chk("idle_valid_busy", 32'(busy), 0);
        end
        start_bundling = 1'b1;
        bound_valid    = gapped;
        bound_hv       = '1;
        @(negedge clk);
        start_bundling = 1'b0;
        bound_valid    = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_hv_count", 32'(hv_count), 0);
        for (int i = 0; i < int'(NUM_HV); i++) begin
            bound_valid = 1'b1;
            bound_hv    = pattern(v, i);
            @(negedge clk);
            bound_valid = 1'b0;
            bound_hv    = '1;
            if (gapped && i < int'(NUM_HV) - 1) begin
                if (i == 40) begin
                    start_bundling = 1'b1;
                    @(negedge clk);
                    start_bundling = 1'b0;
                    chk("mid_start_hv_count", 32'(hv_count), 41);
                end
                g = int'($urandom_range(0, 5));
                repeat (g) @(negedge clk);
            end
        end
        chk("thresh_hv_count", 32'(hv_count), NUM_HV);
        chk("thresh_busy", 32'(busy), 1);
        chk("thresh_bundle_valid", 32'(bundle_valid), 0);
        bound_valid = 1'b1;
        bound_hv    = '1;
        @(negedge clk);
        bound_valid = 1'b0;
        chk("done_bundle_valid", 32'(bundle_valid), 1);
        chk_hv("bundled_thr2", bundled_hv, vecs[v].exp2);
        chk_hv("bundled_thr80", bundled_hv_t80, vecs[v].exp80);
        @(negedge clk);
        chk("idle_bundle_valid", 32'(bundle_valid), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [HV_DIM-1:0] e;
        int p1, p2, pc0;

        for (int v = 0; v < NVEC; v++) begin
            vecs[v].base = '0; vecs[v].ba = 0; vecs[v].na = 0;
            vecs[v].bb = 0; vecs[v].nb = 0;
            vecs[v].exp2 = '0; vecs[v].exp80 = '0;
        end
        vecs[V_ONES].base = '1; vecs[V_ONES].exp2 = '1; vecs[V_ONES].exp80 = '1;
        e = '0; e[1023] = 1'b1;
        vecs[V_EDGE].base = e; vecs[V_EDGE].ba = 5; vecs[V_EDGE].na = 2;
        vecs[V_EDGE].bb = 7; vecs[V_EDGE].nb = 1; vecs[V_EDGE].exp80 = e;
        e[5] = 1'b1; vecs[V_EDGE].exp2 = e;
        e = '0; e[4] = 1'b1;
        vecs[V_PARAM].base = e; vecs[V_PARAM].ba = 3; vecs[V_PARAM].na = 79;
        vecs[V_PARAM].exp80 = e;
        e[3] = 1'b1; vecs[V_PARAM].exp2 = e;
        e = '0; e[0] = 1'b1;
        vecs[4].base = e; vecs[4].ba = 10; vecs[4].na = 1;
        vecs[4].bb = 200; vecs[4].nb = 3; vecs[4].exp80 = e;
        e[200] = 1'b1; vecs[4].exp2 = e;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bundle_valid", 32'(bundle_valid), 0);
        chk("rst_hv_count", 32'(hv_count), 0);
        chk_hv("rst_bundled", bundled_hv, '0);
        nrst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < NVEC; v++) run_sample(v, 1'b0);

        run_sample(V_EDGE, 1'b1);

        // Reset after 40 accepts; previous result (bits 5, 1023) must vanish.
        start_bundling = 1'b1;
        @(negedge clk);
        start_bundling = 1'b0;
        bound_valid = 1'b1;
        bound_hv    = '1;
        repeat (40) @(negedge clk);
        chk("pre_rst_hv_count", 32'(hv_count), 40);
        #2 nrst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_bundle_valid", 32'(bundle_valid), 0);
        chk("midrst_hv_count", 32'(hv_count), 0);
        chk_hv("midrst_bundled", bundled_hv, '0);
        bound_valid = 1'b0;
        @(negedge clk);
        chk("midrst_hold_busy", 32'(busy), 0);
        nrst = 1'b1;
        @(negedge clk);
        run_sample(V_ZERO, 1'b0);

        // Back-to-back with start held high: A all ones, B all zeros.
        pc0 = pulse_cnt;
        start_bundling = 1'b1;
        bound_valid    = 1'b1;
        bound_hv       = '1;
        @(negedge clk);
        repeat (80) @(negedge clk);
        chk("b2b_a_hv_count", 32'(hv_count), 80);
        @(negedge clk);
        chk("b2b_a_valid", 32'(bundle_valid), 1);
        chk_hv("b2b_a_bundled", bundled_hv, '1);
        p1 = cyc;
        @(negedge clk);
        chk("b2b_a_done_busy", 32'(busy), 0);
        @(negedge clk);
        chk("b2b_b_busy", 32'(busy), 1);
        chk("b2b_b_hv_count0", 32'(hv_count), 0);
        bound_hv = '0;
        @(negedge clk);
        chk("b2b_b_hv_count1", 32'(hv_count), 1);
        repeat (79) @(negedge clk);
        chk("b2b_b_hv_count", 32'(hv_count), 80);
        @(negedge clk);
        chk("b2b_b_valid", 32'(bundle_valid), 1);
        chk_hv("b2b_b_bundled", bundled_hv, '0);
        p2 = cyc;
        start_bundling = 1'b0;
        bound_valid    = 1'b0;
        @(negedge clk);
        chk("b2b_pulse_gap", 32'(p2 - p1), 83);
        chk("b2b_pulse_count", 32'(pulse_cnt - pc0), 2);
        chk("b2b_last_pulse", 32'(last_pulse), 32'(p2));
        chk("b2b_end_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
